// File: rtl/arm_decoder.sv
// arm_decoder: main control decoder for the ARM-subset core.
// Decodes op/funct/rd of the current instruction into datapath controls.
// All outputs are registered: decode appears one clock after the inputs.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   op[1:0]       Instr[27:26] (00 DP, 01 memory, 10 branch, 11 NOP)
//   funct[5:0]    Instr[25:20]
//   rd[3:0]       Instr[15:12]
//   pcs, reg_w, mem_w, mem_to_reg, alu_src, reg_src   writeback/operand controls
//   no_write, shift, swap, inv                        operand-modifier controls
//   flag_w[1:0]   [1] N,Z write; [0] C,V write
//   imm_src[1:0]  immediate extension select
//   alu_ctl[2:0]  ALU operation
module arm_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  output logic       pcs,
  output logic       reg_w,
  output logic       mem_w,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic       reg_src,
  output logic       no_write,
  output logic       shift,
  output logic       swap,
  output logic       inv,
  output logic [1:0] flag_w,
  output logic [1:0] imm_src,
  output logic [2:0] alu_ctl
);

  logic       pcs_d, reg_w_d, mem_w_d, mem_to_reg_d, alu_src_d, reg_src_d;
  logic       no_write_d, shift_d, swap_d, inv_d;
  logic [1:0] flag_w_d, imm_src_d;
  logic [2:0] alu_ctl_d;

  logic       pcs_q, reg_w_q, mem_w_q, mem_to_reg_q, alu_src_q, reg_src_q;
  logic       no_write_q, shift_q, swap_q, inv_q;
  logic [1:0] flag_w_q, imm_src_q;
  logic [2:0] alu_ctl_q;

  logic [3:0] cmd;
  logic       arith;

  assign cmd = funct[4:1];

  always_comb begin
    pcs_d        = 1'b0;
    reg_w_d      = 1'b0;
    mem_w_d      = 1'b0;
    mem_to_reg_d = 1'b0;
    alu_src_d    = 1'b0;
    reg_src_d    = 1'b0;
    no_write_d   = 1'b0;
    shift_d      = 1'b0;
    swap_d       = 1'b0;
    inv_d        = 1'b0;
    flag_w_d     = '0;
    imm_src_d    = '0;
    alu_ctl_d    = '0;
    arith        = 1'b0;

    unique case (op)
      2'b00: begin
        alu_src_d = funct[5];
        imm_src_d = 2'b00;
        unique case (cmd)
          4'b0000: alu_ctl_d = 3'b010;
          4'b0001: alu_ctl_d = 3'b101;
          4'b0010: begin alu_ctl_d = 3'b001; arith = 1'b1; end
          4'b0011: begin alu_ctl_d = 3'b001; arith = 1'b1; swap_d = 1'b1; end
          4'b0100: begin alu_ctl_d = 3'b000; arith = 1'b1; end
          4'b0101: begin alu_ctl_d = 3'b100; arith = 1'b1; end
          4'b0110: begin alu_ctl_d = 3'b110; arith = 1'b1; end
          4'b0111: begin alu_ctl_d = 3'b110; arith = 1'b1; swap_d = 1'b1; end
          4'b1000: begin alu_ctl_d = 3'b010; no_write_d = 1'b1; end
          4'b1001: begin alu_ctl_d = 3'b101; no_write_d = 1'b1; end
          4'b1010: begin alu_ctl_d = 3'b001; no_write_d = 1'b1; arith = 1'b1; end
          4'b1011: begin alu_ctl_d = 3'b000; no_write_d = 1'b1; arith = 1'b1; end
          4'b1100: alu_ctl_d = 3'b011;
          4'b1101: begin alu_ctl_d = 3'b000; shift_d = 1'b1; end
          4'b1110: begin alu_ctl_d = 3'b010; inv_d = 1'b1; end
          4'b1111: begin alu_ctl_d = 3'b000; shift_d = 1'b1; inv_d = 1'b1; end
          default: alu_ctl_d = 3'b000;
        endcase
        reg_w_d  = ~no_write_d;
        pcs_d    = reg_w_d & (rd == 4'd15);
        flag_w_d = {funct[0], funct[0] & arith};
      end
      2'b01: begin
        alu_src_d = 1'b1;
        imm_src_d = 2'b01;
        // funct[3] is the U (add offset) bit
        alu_ctl_d = funct[3] ? 3'b000 : 3'b001;
        if (funct[0]) begin
          reg_w_d      = 1'b1;
          mem_to_reg_d = 1'b1;
          pcs_d        = (rd == 4'd15);
        end else begin
          mem_w_d = 1'b1;
        end
      end
      2'b10: begin
        pcs_d     = 1'b1;
        alu_src_d = 1'b1;
        imm_src_d = 2'b10;
        reg_src_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcs_q        <= 1'b0;
      reg_w_q      <= 1'b0;
      mem_w_q      <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_src_q    <= 1'b0;
      no_write_q   <= 1'b0;
      shift_q      <= 1'b0;
      swap_q       <= 1'b0;
      inv_q        <= 1'b0;
      flag_w_q     <= '0;
      imm_src_q    <= '0;
      alu_ctl_q    <= '0;
    end else begin
      pcs_q        <= pcs_d;
      reg_w_q      <= reg_w_d;
      mem_w_q      <= mem_w_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_src_q    <= alu_src_d;
      reg_src_q    <= reg_src_d;
      no_write_q   <= no_write_d;
      shift_q      <= shift_d;
      swap_q       <= swap_d;
      inv_q        <= inv_d;
      flag_w_q     <= flag_w_d;
      imm_src_q    <= imm_src_d;
      alu_ctl_q    <= alu_ctl_d;
    end
  end

  assign pcs        = pcs_q;
  assign reg_w      = reg_w_q;
  assign mem_w      = mem_w_q;
  assign mem_to_reg = mem_to_reg_q;
  assign alu_src    = alu_src_q;
  assign reg_src    = reg_src_q;
  assign no_write   = no_write_q;
  assign shift      = shift_q;
  assign swap       = swap_q;
  assign inv        = inv_q;
  assign flag_w     = flag_w_q;
  assign imm_src    = imm_src_q;
  assign alu_ctl    = alu_ctl_q;

endmodule

// File: tb/tb_arm_decoder.sv
// Self-checking bench for arm_decoder: directed steps from the decode rules,
// then randomized instructions (with occasional reset) against a table model.
module tb_arm_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       pcs, reg_w, mem_w, mem_to_reg, alu_src, reg_src;
  logic       no_write, shift, swap, inv;
  logic [1:0] flag_w, imm_src;
  logic [2:0] alu_ctl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arm_decoder dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd),
    .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .reg_src(reg_src), .no_write(no_write),
    .shift(shift), .swap(swap), .inv(inv), .flag_w(flag_w),
    .imm_src(imm_src), .alu_ctl(alu_ctl)
  );

  // {pcs,reg_w,mem_w,mem_to_reg,alu_src,reg_src,no_write,shift,swap,inv,flag_w,imm_src,alu_ctl}
  logic [16:0] dut_v;
  assign dut_v = {pcs, reg_w, mem_w, mem_to_reg, alu_src, reg_src, no_write,
                  shift, swap, inv, flag_w, imm_src, alu_ctl};

  // ALU operation per DP mnemonic, indexed by cmd
  localparam logic [2:0] ALU_TAB [16] = '{
    3'b010, 3'b101, 3'b001, 3'b001, 3'b000, 3'b100, 3'b110, 3'b110,
    3'b010, 3'b101, 3'b001, 3'b000, 3'b011, 3'b000, 3'b010, 3'b000};

  function automatic logic [16:0] ref_dec(input logic rst, input logic [1:0] o,
                                          input logic [5:0] f, input logic [3:0] r);
    int unsigned cmd;
    logic e_pcs, e_rw, e_mw, e_m2r, e_as, e_rs, e_nw, e_sh, e_sw, e_inv, arith;
    logic [1:0] e_fw, e_is;
    logic [2:0] e_alu;
    {e_pcs, e_rw, e_mw, e_m2r, e_as, e_rs, e_nw, e_sh, e_sw, e_inv} = '0;
    e_fw = '0; e_is = '0; e_alu = '0;
    cmd = int'(f[4:1]);
    if (!rst) begin
      if (o == 2'd0) begin
        e_alu = ALU_TAB[cmd];
        e_as  = f[5];
        e_nw  = (cmd >= 8 && cmd <= 11);
        e_sw  = (cmd == 3 || cmd == 7);
        e_sh  = (cmd == 13 || cmd == 15);
        e_inv = (cmd == 14 || cmd == 15);
        arith = (cmd >= 2 && cmd <= 7) || cmd == 10 || cmd == 11;
        e_rw  = !e_nw;
        e_pcs = e_rw && (r == 15);
        e_fw  = {f[0], f[0] && arith};
      end else if (o == 2'd1) begin
        e_as  = 1'b1;
        e_is  = 2'd1;
        e_alu = f[3] ? 3'd0 : 3'd1;
        if (f[0]) begin e_rw = 1'b1; e_m2r = 1'b1; e_pcs = (r == 15); end
        else e_mw = 1'b1;
      end else if (o == 2'd2) begin
        e_pcs = 1'b1; e_as = 1'b1; e_is = 2'd2; e_rs = 1'b1;
      end
    end
    return {e_pcs, e_rw, e_mw, e_m2r, e_as, e_rs, e_nw, e_sh, e_sw, e_inv,
            e_fw, e_is, e_alu};
  endfunction

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an instruction, clock it in, and sample 1 time unit after the edge
  task automatic step(input logic rst, input logic [1:0] o, input logic [5:0] f,
                      input logic [3:0] r);
    reset = rst; op = o; funct = f; rd = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [16:0] exp_v;
    logic        r_rst;
    logic [1:0]  r_op;
    logic [5:0]  r_f;
    logic [3:0]  r_rd;

    reset = 1'b1; op = '0; funct = '0; rd = '0;
    @(negedge clk);

    // Reset with an ADDS pending, then release
    step(1'b1, 2'b00, 6'b001001, 4'd1);
    chk("reset_all_zero", dut_v, 17'd0);
    step(1'b0, 2'b00, 6'b001001, 4'd1);
    chk("post_reset_reg_w", {16'd0, reg_w}, 17'd1);
    chk("post_reset_flag_w", {15'd0, flag_w}, 17'd3);
    chk("post_reset_alu", {14'd0, alu_ctl}, 17'd0);
    chk("post_reset_full", dut_v, ref_dec(1'b0, 2'b00, 6'b001001, 4'd1));

    // PC select
    step(1'b0, 2'b00, 6'b000000, 4'd0);
    chk("pcs_rd0", {16'd0, pcs}, 17'd0);
    step(1'b0, 2'b00, 6'b000000, 4'd15);
    chk("pcs_rd15", {16'd0, pcs}, 17'd1);
    step(1'b0, 2'b10, 6'b000000, 4'd3);
    chk("branch_fields", {13'd0, pcs, reg_w, imm_src, reg_src},
        {13'd0, 1'b1, 1'b0, 2'b10, 1'b1});
    chk("branch_full", dut_v, ref_dec(1'b0, 2'b10, 6'b000000, 4'd3));

    // Memory
    step(1'b0, 2'b01, 6'b000000, 4'd2);
    chk("str_fields", {12'd0, mem_w, reg_w, imm_src, reg_src},
        {12'd0, 1'b1, 1'b0, 2'b01, 1'b0});
    chk("str_alu_sub", {14'd0, alu_ctl}, 17'd1);
    step(1'b0, 2'b01, 6'b000001, 4'd2);
    chk("ldr_fields", {14'd0, reg_w, mem_to_reg, mem_w}, {14'd0, 3'b110});
    step(1'b0, 2'b01, 6'b001001, 4'd15);
    chk("ldr_pc_u", {13'd0, pcs, alu_ctl}, {13'd0, 1'b1, 3'b000});

    // ALU control
    step(1'b0, 2'b00, 6'b001000, 4'd1);
    chk("alu_add", {14'd0, alu_ctl}, 17'd0);
    step(1'b0, 2'b00, 6'b000100, 4'd1);
    chk("alu_sub", {14'd0, alu_ctl}, 17'd1);
    step(1'b0, 2'b00, 6'b000000, 4'd1);
    chk("alu_and", {14'd0, alu_ctl}, 17'd2);
    step(1'b0, 2'b00, 6'b011000, 4'd1);
    chk("alu_orr", {14'd0, alu_ctl}, 17'd3);
    step(1'b0, 2'b00, 6'b001010, 4'd1);
    chk("alu_adc", {14'd0, alu_ctl}, 17'd4);
    step(1'b0, 2'b00, 6'b100000, 4'd1);
    chk("alu_src_imm", {16'd0, alu_src}, 17'd1);

    // Flags
    step(1'b0, 2'b00, 6'b001000, 4'd1);
    chk("flags_none", {15'd0, flag_w}, 17'd0);
    step(1'b0, 2'b00, 6'b001001, 4'd1);
    chk("flags_adds", {15'd0, flag_w}, 17'd3);
    step(1'b0, 2'b00, 6'b000001, 4'd1);
    chk("flags_ands", {15'd0, flag_w}, 17'd2);
    step(1'b0, 2'b00, 6'b010101, 4'd15);
    chk("cmp_nowrite", {14'd0, no_write, reg_w, pcs}, {14'd0, 3'b100});

    // Modifiers
    step(1'b0, 2'b00, 6'b011011, 4'd1);
    chk("mov_shift", {14'd0, shift, swap, inv}, {14'd0, 3'b100});
    step(1'b0, 2'b00, 6'b000111, 4'd1);
    chk("rsb_swap", {14'd0, shift, swap, inv}, {14'd0, 3'b010});
    step(1'b0, 2'b00, 6'b011101, 4'd1);
    chk("bic_inv", {14'd0, shift, swap, inv}, {14'd0, 3'b001});
    step(1'b0, 2'b00, 6'b001000, 4'd1);
    chk("add_nomod", {14'd0, shift, swap, inv}, {14'd0, 3'b000});

    // Undefined op is a NOP
    step(1'b0, 2'b11, 6'b111111, 4'd15);
    chk("op11_nop", dut_v, 17'd0);

    // Mid-stream reset discards the pending decode
    step(1'b1, 2'b10, 6'b000000, 4'd0);
    chk("midstream_reset", dut_v, 17'd0);
    step(1'b0, 2'b01, 6'b000001, 4'd15);
    chk("after_midreset", dut_v, ref_dec(1'b0, 2'b01, 6'b000001, 4'd15));

    // Randomized back-to-back instructions
    for (int i = 0; i < 400; i++) begin
      r_rst = ($urandom_range(0, 15) == 0);
      r_op  = 2'($urandom_range(0, 3));
      r_f   = 6'($urandom_range(0, 63));
      r_rd  = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      exp_v = ref_dec(r_rst, r_op, r_f, r_rd);
      step(r_rst, r_op, r_f, r_rd);
      chk($sformatf("rand%0d_op%0d_f%0h_rd%0d", i, r_op, r_f, r_rd), dut_v, exp_v);
      // Outputs must hold between edges
      @(negedge clk);
      chk($sformatf("hold%0d", i), dut_v, exp_v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
